// File: rtl/banked_mem_pkg.sv
// rtl/banked_mem_pkg.sv - shared types and address-decode helpers for banked_memory_wrapper
package banked_mem_pkg;

  localparam int unsigned MAX_BANK_W = 3;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [MAX_BANK_W-1:0] bank;
  } rsp_reg_t;

  function automatic logic [63:0] bank_idx(input logic [63:0] addr,
                                           input int unsigned off_bits,
                                           input int unsigned bank_bits);
    return (addr >> off_bits) & ((64'd1 << bank_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] row_idx(input logic [63:0] addr,
                                          input int unsigned off_bits,
                                          input int unsigned bank_bits,
                                          input int unsigned row_bits);
    return (addr >> (off_bits + bank_bits)) & ((64'd1 << row_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/banked_mem_rr_arbiter.sv
// rtl/banked_mem_rr_arbiter.sv - round-robin one-hot grant starting at the supplied pointer
module banked_mem_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % NUM_PORTS);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/banked_memory_wrapper.sv
// rtl/banked_memory_wrapper.sv - N-port, M-bank word-interleaved memory with per-bank round-robin arbitration
// Optional conflict counters are built when BANKED_MEM_PERF_CNT_EN is defined.
module banked_memory_wrapper
  import banked_mem_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int NUM_BANKS       = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  data_req,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  data_addr,
  input  logic [NUM_PORTS-1:0]                  data_we,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] data_be,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  data_wdata,
  output logic [NUM_PORTS-1:0]                  data_gnt,
  output logic [NUM_PORTS-1:0]                  data_rvalid,
  output logic [NUM_PORTS-1:0]                  data_err,
`ifdef BANKED_MEM_PERF_CNT_EN
  output logic [NUM_PORTS-1:0][31:0]            conflict_cnt,
`endif
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  data_rdata
);

  localparam int BE_W       = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(BE_W);
  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int BANK_SEL_W = (NUM_BANKS > 1) ? BANK_BITS : 1;
  localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MEM_BITS   = OFF_BITS + BANK_BITS + BANK_ADDR_WIDTH;
  localparam int ROWS       = 2 ** BANK_ADDR_WIDTH;

  logic [NUM_PORTS-1:0][BANK_SEL_W-1:0]      port_bank;
  logic [NUM_PORTS-1:0][BANK_ADDR_WIDTH-1:0] port_row;
  logic [NUM_PORTS-1:0]                      port_in_range;
  logic [NUM_PORTS-1:0]                      port_bank_gnt;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]       bank_gnt;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]      bank_rdata;
  rsp_reg_t [NUM_PORTS-1:0]                  rsp_q, rsp_d;
  logic [NUM_PORTS-1:0]                      rd_q, rd_d;

  always_comb begin
    port_bank     = '0;
    port_row      = '0;
    port_in_range = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p]     = BANK_SEL_W'(bank_idx(64'(data_addr[p]), OFF_BITS, BANK_BITS));
      port_row[p]      = BANK_ADDR_WIDTH'(row_idx(64'(data_addr[p]), OFF_BITS, BANK_BITS,
                                                  BANK_ADDR_WIDTH));
      port_in_range[p] = (data_addr[p] >> MEM_BITS) == (ADDR_BASE >> MEM_BITS);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_PORTS-1:0]       req;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic                       win_valid, win_we;
    logic [BANK_ADDR_WIDTH-1:0] win_row;
    logic [BE_W-1:0]            win_be;
    logic [DATA_WIDTH-1:0]      win_wdata;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [DATA_WIDTH-1:0]      mem [ROWS];

    always_comb begin
      req = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        req[p] = data_req[p] && port_in_range[p] && (port_bank[p] == BANK_SEL_W'(b));
      end
    end

    banked_mem_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (bank_gnt[b])
    );

    // At most one grant bit is set, so the winner mux is a simple OR-select.
    always_comb begin
      win_valid = 1'b0;
      win_we    = 1'b0;
      win_row   = '0;
      win_be    = '0;
      win_wdata = '0;
      ptr_d     = ptr_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          win_valid = 1'b1;
          win_we    = data_we[p];
          win_row   = port_row[p];
          win_be    = data_be[p];
          win_wdata = data_wdata[p];
          ptr_d     = (p == NUM_PORTS - 1) ? '0 : PTR_W'(p + 1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (win_valid) begin
        if (win_we) begin
          for (int k = 0; k < BE_W; k++) begin
            if (win_be[k]) begin
              mem[win_row][k*8 +: 8] <= win_wdata[k*8 +: 8];
            end
          end
        end else begin
          rdata_q <= mem[win_row];
        end
      end
    end

    assign bank_rdata[b] = rdata_q;
  end

  // Out-of-range requests are accepted immediately and answered with an error.
  always_comb begin
    port_bank_gnt = '0;
    data_gnt      = '0;
    rsp_d         = '0;
    rd_d          = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        port_bank_gnt[p] = port_bank_gnt[p] | bank_gnt[b][p];
      end
      data_gnt[p]     = data_req[p] && (!port_in_range[p] || port_bank_gnt[p]);
      rsp_d[p].valid  = data_gnt[p];
      rsp_d[p].err    = !port_in_range[p];
      rsp_d[p].bank   = MAX_BANK_W'(port_bank[p]);
      rd_d[p]         = !data_we[p];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_q <= '0;
      rd_q  <= '0;
    end else begin
      rsp_q <= rsp_d;
      rd_q  <= rd_d;
    end
  end

  always_comb begin
    data_rvalid = '0;
    data_err    = '0;
    data_rdata  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_rvalid[p] = rsp_q[p].valid;
      data_err[p]    = rsp_q[p].valid && rsp_q[p].err;
      if (rsp_q[p].valid && !rsp_q[p].err && rd_q[p]) begin
        data_rdata[p] = bank_rdata[BANK_SEL_W'(rsp_q[p].bank)];
      end
    end
  end

`ifdef BANKED_MEM_PERF_CNT_EN
  logic [NUM_PORTS-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (data_req[p] && port_in_range[p] && !data_gnt[p] && (cnt_q[p] != '1)) begin
        cnt_d[p] = cnt_q[p] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_banked_memory_wrapper.sv
// tb/tb_banked_memory_wrapper.sv - scoreboard bench for banked_memory_wrapper
module tb_banked_memory_wrapper;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NP-1:0]          data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [NP-1:0][AW-1:0]  data_addr;
  logic [NP-1:0][3:0]     data_be;
  logic [NP-1:0][DW-1:0]  data_wdata, data_rdata;
`ifdef BANKED_MEM_PERF_CNT_EN
  logic [NP-1:0][31:0]    conflict_cnt;
`endif

  banked_memory_wrapper #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BANK_ADDR_WIDTH(BAW), .ADDR_BASE('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_req    (data_req),
    .data_addr   (data_addr),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_err    (data_err),
`ifdef BANKED_MEM_PERF_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .data_rdata  (data_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [NP][$];
  logic [31:0] model [int];
  int          cyc = 0;

  // Scoreboard: pops/compares responses, then pushes expectations for this cycle's grants.
  always @(negedge clk) begin
    exp_t        e;
    int          w;
    logic [31:0] word;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (!rst) begin
        check_eq($sformatf("p%0d_rvalid_in_reset", p), 64'(data_rvalid[p]), 64'd0);
        sb[p].delete();
      end else begin
        if (data_rvalid[p]) begin
          if (sb[p].size() == 0) begin
            check_eq($sformatf("p%0d_unexpected_rvalid", p), 64'd1, 64'd0);
          end else begin
            e = sb[p].pop_front();
            check_eq($sformatf("p%0d_latency", p), 64'(cyc), 64'(e.due));
            check_eq($sformatf("p%0d_err", p), 64'(data_err[p]), 64'(e.err));
            check_eq($sformatf("p%0d_rdata", p), 64'(data_rdata[p]), 64'(e.rdata));
          end
        end else if (sb[p].size() != 0 && sb[p][0].due <= cyc) begin
          check_eq($sformatf("p%0d_missing_rvalid", p), 64'd0, 64'd1);
          void'(sb[p].pop_front());
        end
        if (data_gnt[p]) begin
          e.due   = cyc + 1;
          e.err   = 1'b0;
          e.rdata = 32'h0;
          w       = int'(data_addr[p] >> 2);
          if ((data_addr[p] >> 12) != 0) begin
            e.err = 1'b1;
          end else if (data_we[p]) begin
            word = model.exists(w) ? model[w] : 32'h0;
            for (int k = 0; k < 4; k++) begin
              if (data_be[p][k]) word[k*8 +: 8] = data_wdata[p][k*8 +: 8];
            end
            model[w] = word;
          end else begin
            e.rdata = model.exists(w) ? model[w] : 32'hxxxx_xxxx;
          end
          sb[p].push_back(e);
        end
      end
    end
  end

  task automatic drive(input int p, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    data_req[p]   = 1'b1;
    data_addr[p]  = a;
    data_we[p]    = we;
    data_be[p]    = be;
    data_wdata[p] = wd;
  endtask

  task automatic idle(input int p);
    data_req[p]   = 1'b0;
    data_addr[p]  = '0;
    data_we[p]    = 1'b0;
    data_be[p]    = '0;
    data_wdata[p] = '0;
  endtask

  // Inputs are set just after a rising edge; grants are checked on the falling edge.
  task automatic tick(input string tag, input logic [NP-1:0] exp_gnt);
    @(negedge clk);
    check_eq(tag, 64'(data_gnt), 64'(exp_gnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int p = 0; p < NP; p++) idle(p);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rvalid", 64'(data_rvalid), 64'd0);
    check_eq("reset_err", 64'(data_err), 64'd0);
    check_eq("reset_rdata", 64'(data_rdata), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    drive(0, 32'h0, 1'b1, 4'hF, 32'hDEAD_BEEF);  tick("single_wr_gnt", 2'b01);
    drive(0, 32'h0, 1'b0, 4'hF, 32'h0);          tick("single_rd_gnt", 2'b01);
    idle(0);                                     tick("single_idle", 2'b00);

    drive(0, 32'h8, 1'b1, 4'hF, 32'h1122_3344);  tick("be_wr_full", 2'b01);
    drive(0, 32'h8, 1'b1, 4'h5, 32'hAABB_CCDD);  tick("be_wr_part", 2'b01);
    drive(0, 32'h8, 0, 4'hF, 32'h0);             tick("be_rd", 2'b01);
    idle(0);                                     tick("be_idle", 2'b00);

    // P1 touching bank 0 last leaves the bank-0 pointer back at port 0.
    drive(1, 32'h10, 1'b1, 4'hF, 32'h5A5A_0010); tick("prep_wr", 2'b10);
    idle(1);                                     tick("prep_idle", 2'b00);

    drive(0, 32'h0, 1'b0, 4'hF, 32'h0);
    drive(1, 32'h10, 1'b0, 4'hF, 32'h0);
    tick("conflict_c1", 2'b01);
    tick("conflict_c2", 2'b10);
    tick("conflict_c3", 2'b01);
    idle(0);                                     tick("conflict_c4", 2'b10);
    idle(1);                                     tick("conflict_idle", 2'b00);
`ifdef BANKED_MEM_PERF_CNT_EN
    check_eq("perf_cnt_p0", 64'(conflict_cnt[0]), 64'd1);
    check_eq("perf_cnt_p1", 64'(conflict_cnt[1]), 64'd2);
`endif

    drive(0, 32'h20, 1'b1, 4'hF, 32'h0BAD_0020);
    drive(1, 32'h24, 1'b1, 4'hF, 32'h0BAD_0024);
    tick("parallel_wr", 2'b11);
    drive(0, 32'h24, 1'b0, 4'hF, 32'h0);
    drive(1, 32'h20, 1'b0, 4'hF, 32'h0);
    tick("parallel_rd", 2'b11);
    idle(0); idle(1);                            tick("parallel_idle", 2'b00);

    drive(0, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    drive(1, 32'h0, 1'b0, 4'hF, 32'h0);
    tick("oor_rd", 2'b11);
    drive(0, 32'h0010_0008, 1'b1, 4'hF, 32'hFFFF_FFFF);
    drive(1, 32'h8, 1'b0, 4'hF, 32'h0);
    tick("oor_wr", 2'b11);
    idle(0); idle(1);                            tick("oor_idle", 2'b00);

    drive(0, 32'h0, 1'b0, 4'hF, 32'h0);          tick("rst_rd_gnt", 2'b01);
    idle(0);
    check_eq("rst_pending_rvalid", 64'(data_rvalid[0]), 64'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_rvalid_now", 64'(data_rvalid), 64'd0);
    check_eq("rst_rdata_now", 64'(data_rdata), 64'd0);
`ifdef BANKED_MEM_PERF_CNT_EN
    check_eq("rst_perf_cnt", 64'(conflict_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("post_rst_idle", 2'b00);
      check_eq("post_rst_rvalid", 64'(data_rvalid), 64'd0);
    end

    for (int i = 0; i < 3; i++) tick("drain", 2'b00);
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("p%0d_sb_empty", p), 64'(sb[p].size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_memory_wrapper.md
Name: banked_memory_wrapper

Overview:
- Parametrised N-port, M-bank word-interleaved on-chip data memory with a req/gnt/rvalid/err interface per port.
- Successor to the fixed two-port single-macro wrapper.
- Bank conflicts are resolved by a per-bank round-robin arbiter instead of being flagged as errors.
- Sits between the core/vector-unit load-store ports and the SRAM banks.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..4).
- NUM_BANKS, 4, number of interleaved banks (power of two, 1..8).
- DATA_WIDTH, 32, word width in bits (multiple of 8).
- ADDR_WIDTH, 32, requester byte-address width.
- BANK_ADDR_WIDTH, 8, row address bits per bank.
- ADDR_BASE, '0, base byte address of the memory region (aligned to total size).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- data_req  input  [NUM_PORTS]  request valid per port.
- data_addr  input  [NUM_PORTS][ADDR_WIDTH]  byte address.
- data_we  input  [NUM_PORTS]  1 = write, 0 = read.
- data_be  input  [NUM_PORTS][DATA_WIDTH/8]  byte enables.
- data_wdata  input  [NUM_PORTS][DATA_WIDTH]  write data.
- data_gnt  output  [NUM_PORTS]  request accepted this cycle (combinational).
- data_rvalid  output  [NUM_PORTS]  response valid.
- data_err  output  [NUM_PORTS]  response error; meaningful only with rvalid.
- data_rdata  output  [NUM_PORTS][DATA_WIDTH]  read data; 0 when rvalid=0.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - data_rvalid=0, data_err=0, data_rdata=0.
  - All round-robin pointers=0; memory contents not cleared.
- Address decode:
  - word = addr >> log2(DATA_WIDTH/8).
  - bank = word[log2(NUM_BANKS)-1:0].
  - row = next BANK_ADDR_WIDTH bits.
  - in_range = upper bits of addr equal the upper bits of ADDR_BASE.
- Out-of-range request:
  - Granted the same cycle, no bank access.
  - Next cycle: rvalid=1, err=1, rdata=0.
  - Does not consume arbitration.
- Arbitration, per bank, over in-range requesting ports:
  - Winner is the first requester at or after the bank's pointer, wrapping.
  - Winner gets gnt=1; losers get gnt=0 and must hold req/addr/we/be/wdata stable until granted.
  - On a grant, the pointer becomes winner+1 mod NUM_PORTS. The pointer is unchanged if nothing was granted.
- Access:
  - Granted write updates only the bytes with be=1.
  - Granted read returns the row contents.
- Latency:
  - rvalid asserts exactly 1 cycle after gnt, for reads and writes.
  - Write responses carry rdata=0, err=0.
- Response routing: the granted bank index and the err flag are registered per port, and the next-cycle rdata is muxed from that bank.
- Back-to-back: a port may be granted every cycle. A write at cycle t followed by a read of the same address at t+1 (any port) returns the new data.
- Different banks are accessed in parallel; all ports may be granted in one cycle.
- Reset mid-operation:
  - Pending responses are dropped; no rvalid is issued after reset deasserts.
  - Writes in flight at the reset edge may be lost.

Optional Feature:
- Macro: BANKED_MEM_PERF_CNT_EN.
- Defined:
  - Adds output conflict_cnt [NUM_PORTS][32].
  - Each counter increments on cycles with in-range req=1 and gnt=0.
  - Saturates at 2^32-1; resets to 0.
- Undefined: the port and the counters are absent, with no other behaviour change.

Decomposition:
- Package banked_mem_pkg:
  - Functions bank_idx(addr) and row_idx(addr), parametrised via package parameters or passed widths.
  - Response-register struct {valid, err, bank}.
- Sub-module banked_mem_rr_arbiter:
  - Parameter NUM_PORTS.
  - Inputs req vector, pointer register. Outputs one-hot grant.
  - Instantiated once per bank.
- Banks: behavioural arrays inside a generate loop.

Test Plan:
- Single port: write 0xDEADBEEF to 0x0, be=4'b1111, then read 0x0 → gnt same cycle, rvalid t+1, rdata=0xDEADBEEF, err=0.
- Byte enable: write 0x11223344 to 0x8, then write 0xAABBCCDD with be=4'b0101, then read → rdata=0x11BB33DD.
- Conflict: ports 0 and 1 both read bank 0 (0x0 and 0x10) for 3 consecutive cycles from pointer 0 → grants alternate P0, P1, P0; loser holds; each port gets exactly one rvalid per gnt.
- Parallel: P0 to 0x0, P1 to 0x4 (different banks) → both gnt same cycle, both rvalid next cycle.
- Out of range: read at ADDR_BASE+0x100000 → gnt=1, rvalid t+1 with err=1, rdata=0; a concurrent in-range request from another port to the same bank is unaffected.
- Reset: assert rst low while rvalid is pending → rvalid=0 immediately; after release with no requests, rvalid stays 0. With PERF enabled, conflict_cnt=0.
